// File: rtl/uart_tx_arbiter_if.sv
// Shared UART transmit write port: per-requester byte handshakes on one side,
// the single uart wr_uart/w_data/tx_full port on the other.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DBIT = 8
);
  logic [NREQ-1:0]      req;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      ack;
  logic                 tx_full;
  logic                 wr_uart;
  logic [DBIT-1:0]      w_data;

  modport master (
    output req, req_data, req_last, tx_full,
    input  ack, wr_uart, w_data
  );

  modport slave (
    input  req, req_data, req_last, tx_full,
    output ack, wr_uart, w_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart TX write port among NREQ byte producers.
// Optional byte counter output tx_cnt is enabled by defining UART_ARB_CNT_EN.
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int DBIT      = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  uart_tx_arbiter_if.slave          bus,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy
`ifdef UART_ARB_CNT_EN
  ,
  output logic [15:0]               tx_cnt
`endif
);

  localparam int OW = $clog2(NREQ);
  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_next;
  logic [OW-1:0] owner_next;
  logic [OW-1:0] winner;
  logic [OW-1:0] idx;
  logic          found;
  logic          write;
  logic [7:0]    burst_cnt, burst_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= OW'(NREQ - 1);
      burst_cnt <= '0;
    end else begin
      state     <= state_next;
      owner     <= owner_next;
      burst_cnt <= burst_next;
    end
  end

  // Rotating priority: the search starts just after the last holder, so it is served last.
  always_comb begin
    found  = 1'b0;
    winner = owner;
    idx    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = OW'((32'(owner) + k) % 32'(NREQ));
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_next  = state;
    owner_next  = owner;
    burst_next  = burst_cnt;
    write       = 1'b0;
    bus.wr_uart = 1'b0;
    bus.ack     = '0;
    bus.w_data  = '0;
    case (state)
      IDLE: begin
        if (found) begin
          owner_next = winner;
          burst_next = '0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        write            = bus.req[owner] & ~bus.tx_full;
        bus.wr_uart      = write;
        bus.ack[owner]   = write;
        bus.w_data       = bus.req_data[32'(owner)*DBIT +: DBIT];
        // Last byte and burst limit together still release only once.
        if (!bus.req[owner] ||
            (write && (bus.req_last[owner] || burst_cnt == LAST_BEAT)))
          state_next = IDLE;
        else if (write)
          burst_next = burst_cnt + 8'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == GRANT);

`ifdef UART_ARB_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      tx_cnt <= '0;
    else if (bus.wr_uart)
      tx_cnt <= tx_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed corner sequences, and a
// randomized run against a grant/burst reference model.
module tb_uart_tx_arbiter;

  localparam int NREQ      = 4;
  localparam int DBIT      = 8;
  localparam int MAX_BURST = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] owner;
  logic       busy;
`ifdef UART_ARB_CNT_EN
  logic [15:0] tx_cnt;
`endif

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter_if #(.NREQ(NREQ), .DBIT(DBIT)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .owner (owner),
    .busy  (busy)
`ifdef UART_ARB_CNT_EN
    ,
    .tx_cnt(tx_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic       full;
    logic       wr;
    logic [3:0] ack;
    logic [7:0] data;
    logic       bsy;
    logic [1:0] own;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic f);
    bus.req      = r;
    bus.req_last = l;
    bus.tx_full  = f;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(4'b0000, 4'b0000, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_wr",    32'(bus.wr_uart), 32'd0);
    chk("rst_ack",   32'(bus.ack), 32'd0);
    chk("rst_wdata", 32'(bus.w_data), 32'd0);
    chk("rst_owner", 32'(owner), 32'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
  endtask

  // Reference model: a grant is (holder, bytes sent so far); released on
  // last byte, on the MAX_BURST-th byte, or when the holder drops its request.
  bit m_busy;
  int m_owner;
  int m_sent;
  int m_tx;

  initial begin
    reset        = 1'b1;
    bus.req_data = 32'h44434241;
    drive(4'b0000, 4'b0000, 1'b0);

    //            req      last     full  wr    ack      data   busy  own
    tbl[0] = '{4'b0001, 4'b0001, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd3};
    tbl[1] = '{4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0001, 8'h41, 1'b1, 2'd0};
    tbl[2] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0};
    tbl[3] = '{4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0};
    tbl[4] = '{4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0000, 8'h43, 1'b1, 2'd2};
    tbl[5] = '{4'b0100, 4'b0000, 1'b0, 1'b1, 4'b0100, 8'h43, 1'b1, 2'd2};
    tbl[6] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h43, 1'b1, 2'd2};
    tbl[7] = '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd2};
    tbl[8] = '{4'b1111, 4'b0000, 1'b0, 1'b1, 4'b1000, 8'h44, 1'b1, 2'd3};

    #3;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].req, tbl[i].last, tbl[i].full);
      @(negedge clk);
      chk($sformatf("tbl%0d_wr", i),    32'(bus.wr_uart), 32'(tbl[i].wr));
      chk($sformatf("tbl%0d_ack", i),   32'(bus.ack),     32'(tbl[i].ack));
      chk($sformatf("tbl%0d_data", i),  32'(bus.w_data),  32'(tbl[i].data));
      chk($sformatf("tbl%0d_busy", i),  32'(busy),        32'(tbl[i].bsy));
      chk($sformatf("tbl%0d_owner", i), 32'(owner),       32'(tbl[i].own));
      next_cycle();
    end

    // All four requesting: bursts of MAX_BURST, one idle cycle between grants.
    do_reset();
    drive(4'b1111, 4'b0000, 1'b0);
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      chk($sformatf("rr_c%0d_ack", c), 32'(bus.ack),
          (c % 5 == 0) ? 32'd0 : (32'd1 << ((c / 5) % 4)));
      next_cycle();
    end

    // Owner 2 stalled by tx_full for 10 cycles after one byte, then finishes its burst.
    do_reset();
    drive(4'b0100, 4'b0000, 1'b0);
    @(negedge clk);
    chk("stall_idle_busy", 32'(busy), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("stall_first_ack", 32'(bus.ack), 32'b0100);
    next_cycle();
    drive(4'b0100, 4'b0000, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_wr", c),   32'(bus.wr_uart), 32'd0);
      chk($sformatf("stall%0d_ack", c),  32'(bus.ack), 32'd0);
      chk($sformatf("stall%0d_busy", c), 32'(busy), 32'd1);
      next_cycle();
    end
    drive(4'b0100, 4'b0000, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("resume%0d_ack", c), 32'(bus.ack), 32'b0100);
      next_cycle();
    end
    @(negedge clk);
    chk("resume_release_busy", 32'(busy), 32'd0);
    chk("resume_owner", 32'(owner), 32'd2);
    next_cycle();

    // Owner 1 withdraws after two bytes; next search starts at 2 and finds 3 before 0.
    do_reset();
    drive(4'b0010, 4'b0000, 1'b0);
    next_cycle();
    next_cycle();
    next_cycle();
    drive(4'b1001, 4'b0000, 1'b0);
    @(negedge clk);
    chk("drop_wr", 32'(bus.wr_uart), 32'd0);
    chk("drop_busy", 32'(busy), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("drop_idle_busy", 32'(busy), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("drop_next_owner", 32'(owner), 32'd3);
    chk("drop_next_ack", 32'(bus.ack), 32'b1000);
    next_cycle();

    // Asynchronous reset during owner 3's grant, then lowest set index wins.
    do_reset();
    drive(4'b1000, 4'b0000, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("arst_pre_ack", 32'(bus.ack), 32'b1000);
    next_cycle();
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_wr",   32'(bus.wr_uart), 32'd0);
    drive(4'b1001, 4'b0000, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("arst_owner", 32'(owner), 32'd0);
    chk("arst_ack",   32'(bus.ack), 32'b0001);
    next_cycle();

    // Randomized run against the reference model.
    do_reset();
    m_busy = 1'b0; m_owner = NREQ - 1; m_sent = 0; m_tx = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] r, l;
      logic       f, exp_wr;
      logic [7:0] exp_data;
      logic [31:0] d;
      for (int b = 0; b < NREQ; b++) begin
        r[b] = ($urandom_range(0, 3) != 0);
        l[b] = ($urandom_range(0, 7) == 0);
      end
      f = ($urandom_range(0, 3) == 0);
      d = $urandom;
      bus.req_data = d;
      drive(r, l, f);
      @(negedge clk);
      exp_wr   = m_busy && r[m_owner] && !f;
      exp_data = m_busy ? d[m_owner*8 +: 8] : 8'h00;
      chk("rnd_wr",    32'(bus.wr_uart), 32'(exp_wr));
      chk("rnd_ack",   32'(bus.ack), exp_wr ? (32'd1 << m_owner) : 32'd0);
      chk("rnd_data",  32'(bus.w_data), 32'(exp_data));
      chk("rnd_busy",  32'(busy), 32'(m_busy));
      chk("rnd_owner", 32'(owner), 32'(m_owner));
`ifdef UART_ARB_CNT_EN
      chk("rnd_txcnt", 32'(tx_cnt), 32'(m_tx % 65536));
`endif
      if (!m_busy) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (!m_busy && r[(m_owner + k) % NREQ]) begin
            m_busy  = 1'b1;
            m_owner = (m_owner + k) % NREQ;
            m_sent  = 0;
          end
        end
      end else if (!r[m_owner]) begin
        m_busy = 1'b0;
      end else if (exp_wr) begin
        m_sent++;
        m_tx++;
        if (l[m_owner] || m_sent == MAX_BURST) m_busy = 1'b0;
      end
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
